// File: rtl/mem_stage_lsu.sv
// Memory-access stage of the RV32I pipeline: drives a req/gnt/rvalid data port,
// formats store lanes, extracts and extends load data, and stalls upstream while busy.
module mem_stage_lsu #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_out,
  output logic [4:0]  rd_mem,
  output logic        mem_valid,
  output logic        exc_misalign,
  output logic        exc_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg;
  logic [7:0]  wait_cnt_reg;
  logic [31:0] addr_reg;
  logic [2:0]  funct3_reg;
  logic [4:0]  rd_reg;
  logic        reg_write_reg;
  logic        load_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;

  logic        is_mem, is_load, legal_f3, aligned, illegal, accept;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata;
  logic        busy, rsp_done, timeout;
  logic [7:0]  rbyte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_data;

  // A load/store pair with both flags set is handled as a load.
  assign is_load = ex_mem_read;
  assign is_mem  = ex_valid & (ex_mem_read | ex_mem_write);

  always_comb begin
    legal_f3 = 1'b0;
    aligned  = 1'b1;
    unique case (ex_funct3)
      3'b000:  legal_f3 = 1'b1;
      3'b001:  begin legal_f3 = 1'b1; aligned = ~ex_alu_result[0]; end
      3'b010:  begin legal_f3 = 1'b1; aligned = (ex_alu_result[1:0] == 2'b00); end
      3'b100:  legal_f3 = is_load;
      3'b101:  begin legal_f3 = is_load; aligned = ~ex_alu_result[0]; end
      default: legal_f3 = 1'b0;
    endcase
  end

  assign illegal = is_mem & ~(legal_f3 & aligned);
  assign accept  = (state_reg == IDLE) & is_mem & ~illegal;

  always_comb begin
    ex_be    = 4'b1111;
    ex_wdata = 32'd0;
    if (!is_load) begin
      unique case (ex_funct3[1:0])
        2'b00: begin
          ex_be    = 4'b0001 << ex_alu_result[1:0];
          ex_wdata = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          ex_be    = ex_alu_result[1] ? 4'b1100 : 4'b0011;
          ex_wdata = {2{ex_store_data[15:0]}};
        end
        default: ex_wdata = ex_store_data;
      endcase
    end
  end

  assign busy     = (state_reg == REQ) | (state_reg == RSP);
  assign rsp_done = (state_reg == RSP) & dmem_rvalid;
  // A response arriving on the last allowed cycle still completes normally.
  assign timeout  = busy & ~rsp_done & (wait_cnt_reg == WAIT_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = dmem_rdata[8*gi +: 8];
  end

  assign sel_byte = rbyte[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    unique case (funct3_reg)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 8'd0;
      addr_reg      <= 32'd0;
      funct3_reg    <= 3'd0;
      rd_reg        <= 5'd0;
      reg_write_reg <= 1'b0;
      load_reg      <= 1'b0;
      be_reg        <= 4'd0;
      wdata_reg     <= 32'd0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (accept) begin
            addr_reg      <= ex_alu_result;
            funct3_reg    <= ex_funct3;
            rd_reg        <= ex_rd;
            reg_write_reg <= ex_reg_write;
            load_reg      <= is_load;
            be_reg        <= ex_be;
            wdata_reg     <= ex_wdata;
            wait_cnt_reg  <= 8'd0;
            state_reg     <= dmem_gnt ? RSP : REQ;
          end
        end
        REQ: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (timeout)       state_reg <= IDLE;
          else if (dmem_gnt) state_reg <= RSP;
        end
        RSP: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (rsp_done || timeout) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Outputs are combinational so a new access issues its request in the same
  // cycle; rst forces them low immediately, independent of the clock.
  always_comb begin
    stall        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = 32'd0;
    dmem_be      = 4'd0;
    dmem_wdata   = 32'd0;
    mem_out      = 32'd0;
    rd_mem       = 5'd0;
    mem_valid    = 1'b0;
    exc_misalign = 1'b0;
    exc_timeout  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        mem_out = ex_alu_result;
        if (!is_mem) begin
          rd_mem    = (ex_valid & ex_reg_write) ? ex_rd : 5'd0;
          mem_valid = ex_valid;
        end else if (illegal) begin
          exc_misalign = 1'b1;
          mem_valid    = 1'b1;
        end else begin
          stall      = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = ~is_load;
          dmem_addr  = {ex_alu_result[31:2], 2'b00};
          dmem_be    = ex_be;
          dmem_wdata = ex_wdata;
        end
      end
      REQ: begin
        if (timeout) begin
          exc_timeout = 1'b1;
          mem_valid   = 1'b1;
        end else begin
          stall      = 1'b1;
          dmem_req   = 1'b1;
          dmem_we    = ~load_reg;
          dmem_addr  = {addr_reg[31:2], 2'b00};
          dmem_be    = be_reg;
          dmem_wdata = wdata_reg;
        end
      end
      RSP: begin
        if (rsp_done) begin
          mem_valid = 1'b1;
          if (load_reg) begin
            mem_out = load_data;
            rd_mem  = reg_write_reg ? rd_reg : 5'd0;
          end
        end else if (timeout) begin
          exc_timeout = 1'b1;
          mem_valid   = 1'b1;
        end else begin
          stall = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) begin
      stall        = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      dmem_addr    = 32'd0;
      dmem_be      = 4'd0;
      dmem_wdata   = 32'd0;
      mem_out      = 32'd0;
      rd_mem       = 5'd0;
      mem_valid    = 1'b0;
      exc_misalign = 1'b0;
      exc_timeout  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed cases plus random loads/stores, with the
// bench acting as the data memory and an arithmetic model of RV32I access rules.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [2:0]  ex_funct3;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_out;
  logic [4:0]  rd_mem;
  logic        mem_valid;
  logic        exc_misalign;
  logic        exc_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  mem_stage_lsu #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_out(mem_out), .rd_mem(rd_mem), .mem_valid(mem_valid),
    .exc_misalign(exc_misalign), .exc_timeout(exc_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access rules written from the ISA view: size in bytes, address modulo size.
  function automatic bit exp_legal(input logic [2:0] f3, input bit ld, input logic [31:0] a);
    int unsigned sz;
    if (!ld && f3 > 3'd2) return 1'b0;
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    return 1'b0;
    endcase
    return (a % sz) == 0;
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input bit ld, input logic [31:0] a);
    if (ld) return 4'hF;
    case (f3)
      3'd0:    return 4'(1 << (a % 4));
      3'd1:    return (a % 4 >= 2) ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d % 256) * 32'h01010101;
      3'd1:    return (d % 65536) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = (r >> (8 * off)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (r >> ((off >= 2) ? 16 : 0)) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
      end
      default: v = r;
    endcase
    return v;
  endfunction

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic pass_op(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                         input logic vld, input logic rv, input string tag);
    @(posedge clk); #1;
    ex_valid = vld; ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'($urandom_range(0, 7));
    dmem_rvalid = rv; dmem_rdata = $urandom;
    @(negedge clk);
    chk({tag, ".mem_out"}, mem_out, alu);
    chk({tag, ".rd_mem"}, 32'(rd_mem), (vld && rw) ? 32'(rd) : 32'd0);
    chk({tag, ".mem_valid"}, 32'(mem_valid), 32'(vld));
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".req"}, 32'(dmem_req), 32'd0);
    $display("pass %s alu=%h rd=%0d rw=%0d vld=%0d -> mem_out=%h rd_mem=%0d",
             tag, alu, rd, rw, vld, mem_out, rd_mem);
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // The bench plays the memory: grant after gd REQ cycles, respond rdl cycles after grant.
  task automatic access(input logic [31:0] a, input logic [2:0] f3, input logic rd_en,
                        input logic wr_en, input logic [4:0] rd, input logic rw,
                        input logic [31:0] sdata, input int gd, input int rdl,
                        input logic [31:0] rdata, input string tag, output logic [31:0] got);
    bit ld, legal;
    ld    = rd_en;
    legal = exp_legal(f3, ld, a);
    got   = 32'd0;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_alu_result = a; ex_store_data = sdata; ex_funct3 = f3;
    ex_mem_read = rd_en; ex_mem_write = wr_en; ex_rd = rd; ex_reg_write = rw;
    dmem_gnt = (gd == 0); dmem_rvalid = 1'b0;
    @(negedge clk);
    if (!legal) begin
      chk({tag, ".misalign"}, 32'(exc_misalign), 32'd1);
      chk({tag, ".req"}, 32'(dmem_req), 32'd0);
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
      chk({tag, ".rd_mem"}, 32'(rd_mem), 32'd0);
      $display("access %s addr=%h f3=%0d ld=%0d -> illegal, misalign=%0d", tag, a, f3, ld, exc_misalign);
    end else begin
      chk({tag, ".req"}, 32'(dmem_req), 32'd1);
      chk({tag, ".stall"}, 32'(stall), 32'd1);
      chk({tag, ".misalign"}, 32'(exc_misalign), 32'd0);
      chk({tag, ".we"}, 32'(dmem_we), 32'(!ld));
      chk({tag, ".addr"}, dmem_addr, a - (a % 4));
      chk({tag, ".be"}, 32'(dmem_be), 32'(exp_be(f3, ld, a)));
      if (!ld) chk({tag, ".wdata"}, dmem_wdata, exp_wdata(f3, sdata));
      for (int i = 1; i <= gd; i++) begin
        @(posedge clk); #1;
        dmem_gnt = (i == gd);
        dmem_rvalid = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk({tag, ".req_hold"}, 32'(dmem_req), 32'd1);
        chk({tag, ".stall_req"}, 32'(stall), 32'd1);
        chk({tag, ".addr_hold"}, dmem_addr, a - (a % 4));
        chk({tag, ".be_hold"}, 32'(dmem_be), 32'(exp_be(f3, ld, a)));
        chk({tag, ".mv_req"}, 32'(mem_valid), 32'd0);
      end
      @(posedge clk); #1;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      for (int i = 1; i < rdl; i++) begin
        @(negedge clk);
        chk({tag, ".req_rsp"}, 32'(dmem_req), 32'd0);
        chk({tag, ".stall_rsp"}, 32'(stall), 32'd1);
        chk({tag, ".mv_rsp"}, 32'(mem_valid), 32'd0);
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      @(negedge clk);
      got = mem_out;
      chk({tag, ".stall_done"}, 32'(stall), 32'd0);
      chk({tag, ".mem_valid"}, 32'(mem_valid), 32'd1);
      chk({tag, ".rd_mem"}, 32'(rd_mem), (ld && rw) ? 32'(rd) : 32'd0);
      if (ld) chk({tag, ".mem_out"}, mem_out, exp_load(f3, a, rdata));
      $display("access %s addr=%h f3=%0d ld=%0d gd=%0d rdl=%0d rdata=%h -> mem_out=%h rd_mem=%0d",
               tag, a, f3, ld, gd, rdl, rdata, mem_out, rd_mem);
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  logic [31:0] got;
  logic [2:0]  ld_f3_tab [10];
  logic [2:0]  st_f3_tab [5];

  initial begin
    ld_f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    st_f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};
    rst = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'h55; ex_store_data = 32'd0; ex_funct3 = 3'd0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b1; ex_rd = 5'd7;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
    #3;
    chk("reset.mem_valid", 32'(mem_valid), 32'd0);
    chk("reset.mem_out", mem_out, 32'd0);
    chk("reset.rd_mem", 32'(rd_mem), 32'd0);
    chk("reset.stall", 32'(stall), 32'd0);
    chk("reset.req", 32'(dmem_req), 32'd0);
    $display("reset outputs: mem_valid=%0d mem_out=%h stall=%0d", mem_valid, mem_out, stall);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();

    pass_op(32'h00001234, 5'd5, 1'b1, 1'b1, 1'b0, "alu_pass");
    pass_op(32'hCAFE0000, 5'd9, 1'b1, 1'b0, 1'b0, "bubble");
    pass_op(32'h0000BEEF, 5'd3, 1'b0, 1'b1, 1'b1, "rvalid_idle");

    access(32'h103, 3'd0, 1'b1, 1'b0, 5'd6, 1'b1, 32'd0, 2, 1, 32'h80FF0000, "lb_103", got);
    chk("lb_103.literal", got, 32'hFFFFFF80);
    access(32'h103, 3'd4, 1'b1, 1'b0, 5'd6, 1'b1, 32'd0, 2, 1, 32'h80FF0000, "lbu_103", got);
    chk("lbu_103.literal", got, 32'h00000080);
    access(32'h102, 3'd1, 1'b0, 1'b1, 5'd4, 1'b1, 32'hABCD1234, 0, 1, 32'd0, "sh_102", got);
    access(32'h101, 3'd2, 1'b1, 1'b0, 5'd8, 1'b1, 32'd0, 0, 1, 32'd0, "lw_101", got);
    access(32'h100, 3'd3, 1'b1, 1'b0, 5'd8, 1'b1, 32'd0, 0, 1, 32'd0, "f3_011", got);
    access(32'h0F6, 3'd5, 1'b1, 1'b1, 5'd2, 1'b1, 32'h11112222, 1, 2, 32'h9ABC5678, "rw_both", got);

    // Grant never arrives: abort on the eighth cycle after issue.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_alu_result = 32'h40; ex_funct3 = 3'd2; ex_mem_read = 1'b1;
    ex_mem_write = 1'b0; ex_rd = 5'd10; ex_reg_write = 1'b1; dmem_gnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("timeout.stall", 32'(stall), 32'd1);
      chk("timeout.req", 32'(dmem_req), 32'd1);
      chk("timeout.early", 32'(exc_timeout), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("timeout.pulse", 32'(exc_timeout), 32'd1);
    chk("timeout.mem_valid", 32'(mem_valid), 32'd1);
    chk("timeout.rd_mem", 32'(rd_mem), 32'd0);
    chk("timeout.req_drop", 32'(dmem_req), 32'd0);
    chk("timeout.stall_drop", 32'(stall), 32'd0);
    $display("timeout: exc_timeout=%0d req=%0d stall=%0d", exc_timeout, dmem_req, stall);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("timeout.one_cycle", 32'(exc_timeout), 32'd0);
    access(32'h44, 3'd2, 1'b1, 1'b0, 5'd11, 1'b1, 32'd0, 1, 1, 32'h01234567, "lw_after_to", got);

    // Reset while waiting for the response.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_alu_result = 32'h300; ex_funct3 = 3'd2; ex_mem_read = 1'b1;
    ex_mem_write = 1'b0; ex_rd = 5'd12; ex_reg_write = 1'b1; dmem_gnt = 1'b1;
    @(posedge clk); #1;
    dmem_gnt = 1'b0;
    @(negedge clk);
    chk("rst_rsp.stall_before", 32'(stall), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_rsp.stall", 32'(stall), 32'd0);
    chk("rst_rsp.req", 32'(dmem_req), 32'd0);
    chk("rst_rsp.mem_valid", 32'(mem_valid), 32'd0);
    chk("rst_rsp.mem_out", mem_out, 32'd0);
    $display("reset in RSP: stall=%0d req=%0d mem_valid=%0d", stall, dmem_req, mem_valid);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    access(32'h200, 3'd2, 1'b1, 1'b0, 5'd13, 1'b1, 32'd0, 0, 1, 32'hDEADBEEF, "lw_200", got);
    chk("lw_200.literal", got, 32'hDEADBEEF);

    for (int n = 0; n < 48; n++) begin
      int kind;
      logic [31:0] a;
      logic [2:0] f3;
      logic rdn, wrn;
      kind = $urandom_range(0, 9);
      a = ($urandom & 32'h0000FFFC) | (($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(0, 3)));
      if (kind < 2) begin
        pass_op($urandom, 5'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rnd_pass");
      end else begin
        rdn = (kind < 6);
        wrn = !rdn || (kind == 5);
        f3 = rdn ? ld_f3_tab[$urandom_range(0, 9)] : st_f3_tab[$urandom_range(0, 4)];
        access(a, f3, rdn, wrn, 5'($urandom), 1'($urandom), $urandom,
               $urandom_range(0, 3), $urandom_range(1, 4), $urandom, "rnd_mem", got);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-access stage of the in-order 5-stage RV32I pipeline, between the EX/MEM register and the MEM/WB register. It performs loads and stores against a req/gnt/rvalid data-memory port, handling byte lanes, sign/zero extension, misalignment and wait states. It produces the writeback value (mem_out) and destination register (rd_mem) consumed by the MEM/WB register. While an access is outstanding it stalls the upstream pipeline.

Parameters:
MAX_WAIT, 255, cycles allowed from request issue to rvalid before abort (1..255).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
ex_valid  in  1  EX/MEM holds a valid instruction.
ex_alu_result  in  32  ALU result / effective address.
ex_store_data  in  32  rs2 value for stores.
ex_funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
ex_mem_read  in  1  instruction is a load.
ex_mem_write  in  1  instruction is a store.
ex_reg_write  in  1  instruction writes rd.
ex_rd  in  5  destination register.
stall  out  1  hold EX/MEM and earlier stages.
dmem_req  out  1  access request.
dmem_we  out  1  1 = write.
dmem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
dmem_be  out  4  byte enables.
dmem_wdata  out  32  lane-replicated store data.
dmem_gnt  in  1  request accepted.
dmem_rvalid  in  1  response / write-ack valid.
dmem_rdata  in  32  read data.
mem_out  out  32  writeback data to MEM/WB.
rd_mem  out  5  writeback register to MEM/WB; 0 = no write.
mem_valid  out  1  instruction retires from this stage this cycle.
exc_misalign  out  1  misaligned or illegal-funct3 access (1-cycle pulse).
exc_timeout  out  1  access aborted after MAX_WAIT cycles (1-cycle pulse).

Behaviour:
- Reset (async, and while rst high): state IDLE, wait counter 0, latched addr/funct3 0. All outputs 0.
- FSM states: IDLE, REQ (awaiting gnt), RSP (awaiting rvalid).
- IDLE, non-memory or ex_valid=0: mem_out=ex_alu_result, rd_mem=(ex_valid&ex_reg_write)?ex_rd:0, mem_valid=ex_valid, stall=0. Combinational, 0-cycle latency.
- mem_read and mem_write both set: treated as a load.
- Legality check in IDLE: funct3 not in {000,001,010,100,101} (stores: not in {000,001,010}), H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0 -> exc_misalign=1, no dmem_req, mem_valid=1, rd_mem=0, stall=0, remain IDLE.
- Legal access in IDLE: dmem_req=1 the same cycle, stall=1. Latch addr[1:0], funct3, rd, reg_write and the load/store type. If dmem_gnt then RSP, else REQ.
- REQ: hold req, we, addr, be and wdata stable with stall=1. On gnt go to RSP.
- RSP: dmem_req=0, stall=1 until the dmem_rvalid cycle.
- On rvalid, in the same cycle: stall=0, mem_valid=1, go to IDLE.
  - Load: mem_out = extracted data, rd_mem = reg_write ? rd : 0.
  - Store: rd_mem = 0.
- Next instruction is accepted in the cycle after rvalid; accesses never overlap. Minimum memory-op latency is 2 cycles (req+gnt, then rvalid).
- rvalid in IDLE or REQ is ignored. Memory must not respond after a timeout.
- Store lanes (dmem_we=1):
  - SB: be=1<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{data[15:0]}}.
  - SW: be=1111, wdata=data.
- Loads: dmem_we=0, be=1111.
- Load extract: byte lane = rdata[8*a+7:8*a] with a = latched addr[1:0]; halfword = rdata[31:16] if addr[1], else rdata[15:0]. B/H sign-extend; BU/HU zero-extend.
- Wait counter: cleared on acceptance, increments each cycle in REQ/RSP. Reaching MAX_WAIT without rvalid forces the following in that cycle: exc_timeout=1, mem_valid=1, rd_mem=0, req=0, stall=0, go to IDLE.
- rst asserted in REQ/RSP: immediate abort, req and stall drop asynchronously, no retirement.

Test Plan:
- ALU pass-through: ex_valid=1, alu_result=0x00001234, rd=5, reg_write=1, no mem -> same cycle mem_out=0x00001234, rd_mem=5, mem_valid=1, stall=0.
- LB at 0x103, gnt delayed 2 cycles, rvalid 1 cycle later, rdata=0x80FF0000 -> dmem_addr=0x100, stall high 3 cycles, then mem_out=0xFFFFFF80. Repeat as LBU -> mem_out=0x00000080.
- SH at 0x102, store_data=0xABCD1234, immediate gnt -> dmem_we=1, be=1100, wdata=0x12341234, addr=0x100; on rvalid rd_mem=0, mem_valid=1.
- LW at 0x101 -> exc_misalign=1 same cycle, dmem_req never asserted, stall=0, rd_mem=0. Repeat with funct3=011 -> exc_misalign=1.
- MAX_WAIT=8, gnt tied 0 -> stall high 8 cycles, then exc_timeout pulse, req drops, next LW completes normally.
- rst pulsed while in RSP -> req/stall 0 immediately, outputs 0. After release, LW at 0x200 with rdata=0xDEADBEEF -> mem_out=0xDEADBEEF.
